// File: rtl/fetch_queue_unit.sv
// ============================================================================
// Module   : fetch_queue_unit
// Brief    : Prefetching instruction fetch unit with a DEPTH-entry queue
//            between the 32-bit instruction memory port and the decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_unit #(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              a_rst,
   output logic              mem_req,
   output logic [ADDR_W+1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_data,
   input  logic              pc_w,
   input  logic [ADDR_W+1:0] pc_alu,
   input  logic              ir_pop,
   output logic              ir_valid,
   output logic [15:0]       ir_out,
   output logic [15:0]       k16_out,
   output logic [ADDR_W+1:0] pc_out
);

   localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

   localparam logic [0:0] c_idle = 1'b0;
   localparam logic [0:0] c_wait = 1'b1;

   logic [0:0]          r_state;
   logic [ADDR_W-1:0]   r_fpc;
   logic                r_drop;
   logic                r_mem_req;
   logic [ADDR_W+1:0]   r_mem_addr;
   logic [c_ptr_w-1:0]  r_rp;
   logic [c_ptr_w-1:0]  r_wp;
   logic [c_cnt_w-1:0]  r_count;
   logic [31:0]         r_data [DEPTH];
   logic [ADDR_W-1:0]   r_epc  [DEPTH];

   logic w_busy;
   logic w_credit;
   logic w_push;
   logic w_pop;
   logic w_unused;

   assign w_busy   = (r_state == c_wait);
   // Counting the outstanding request as a reserved slot keeps the queue from overflowing
   assign w_credit = ({1'b0, r_count} + {{c_cnt_w{1'b0}}, w_busy}) < c_depth;
   assign w_push   = w_busy & mem_ack & ~r_drop & ~pc_w;
   assign w_pop    = ir_pop & ir_valid & ~pc_w;
   assign w_unused = ^pc_alu[1:0];

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         r_state    <= c_idle;
         r_fpc      <= '0;
         r_drop     <= 1'b0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_credit && !pc_w) begin
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= {r_fpc, 2'b00};
                  r_state    <= c_wait;
               end
            end
            c_wait: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_drop    <= 1'b0;
                  r_state   <= c_idle;
               end else if (pc_w) begin
                  r_drop <= 1'b1;
               end
            end
            default: r_state <= c_idle;
         endcase

         if (pc_w) begin
            r_fpc <= pc_alu[ADDR_W+1:2];
         end else if (w_push) begin
            r_fpc <= r_fpc + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         r_rp    <= '0;
         r_wp    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
            r_epc[i]  <= '0;
         end
      end else if (pc_w) begin
         r_rp    <= '0;
         r_wp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_data[r_wp] <= mem_data;
            r_epc[r_wp]  <= r_fpc;
            r_wp         <= r_wp + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rp <= r_rp + c_ptr_w'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;
   assign ir_valid = (r_count != '0);
   assign ir_out   = r_data[r_rp][31:16];
   assign k16_out  = r_data[r_rp][15:0];
   assign pc_out   = {r_epc[r_rp], 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
// ============================================================================
// Module   : tb_fetch_queue_unit
// Brief    : Directed scoreboard bench for fetch_queue_unit (default and a
//            small ADDR_W=4 / DEPTH=2 instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue_unit;

   logic clk = 1'b0;
   logic a_rst;
   always #5 clk = ~clk;

   // index 0: default instance, index 1: ADDR_W=4, DEPTH=2 instance
   logic        req   [2];
   logic        ack   [2];
   logic        valid [2];
   logic        pcw   [2];
   logic        pop   [2];
   logic [31:0] mdata [2];
   logic [15:0] ir    [2];
   logic [15:0] k16   [2];
   logic [15:0] addr_a, pcalu_a, pco_a;
   logic [5:0]  addr_b, pcalu_b, pco_b;

   int sel = 0;
   int total = 0;
   int bad = 0;
   logic [47:0] sb [$];
   logic [47:0] e;

   fetch_queue_unit #(.ADDR_W(14), .DEPTH(4)) u_dut_a (
      .clk(clk), .a_rst(a_rst),
      .mem_req(req[0]), .mem_addr(addr_a), .mem_ack(ack[0]), .mem_data(mdata[0]),
      .pc_w(pcw[0]), .pc_alu(pcalu_a), .ir_pop(pop[0]),
      .ir_valid(valid[0]), .ir_out(ir[0]), .k16_out(k16[0]), .pc_out(pco_a)
   );

   fetch_queue_unit #(.ADDR_W(4), .DEPTH(2)) u_dut_b (
      .clk(clk), .a_rst(a_rst),
      .mem_req(req[1]), .mem_addr(addr_b), .mem_ack(ack[1]), .mem_data(mdata[1]),
      .pc_w(pcw[1]), .pc_alu(pcalu_b), .ir_pop(pop[1]),
      .ir_valid(valid[1]), .ir_out(ir[1]), .k16_out(k16[1]), .pc_out(pco_b)
   );

   function automatic logic [15:0] f_addr();
      return (sel == 1) ? {10'b0, addr_b} : addr_a;
   endfunction

   function automatic logic [15:0] f_pco();
      return (sel == 1) ? {10'b0, pco_b} : pco_a;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (req[sel] !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("req_wait", 48'(req[sel]), 48'h1);
   endtask

   // keep=0: the ack is expected to be discarded as stale
   task automatic ack_word(input logic [15:0] exp_addr, input logic [31:0] data, input bit keep);
      wait_req();
      chk("mem_addr", 48'(f_addr()), 48'(exp_addr));
      ack[sel]   = 1'b1;
      mdata[sel] = data;
      if (keep) sb.push_back({data, exp_addr});
      tick();
      ack[sel] = 1'b0;
   endtask

   task automatic head_chk();
      chk("ir_valid", 48'(valid[sel]), 48'h1);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 48'(sb.size()), 48'h1);
      end else begin
         e = sb.pop_front();
         chk("ir_out", 48'(ir[sel]), 48'(e[47:32]));
         chk("k16_out", 48'(k16[sel]), 48'(e[31:16]));
         chk("pc_out", 48'(f_pco()), 48'(e[15:0]));
      end
   endtask

   task automatic pop_chk();
      head_chk();
      pop[sel] = 1'b1;
      tick();
      pop[sel] = 1'b0;
   endtask

   task automatic redirect(input logic [15:0] a);
      pcw[sel] = 1'b1;
      if (sel == 1) pcalu_b = a[5:0];
      else          pcalu_a = a;
      sb.delete();
      tick();
      pcw[sel] = 1'b0;
   endtask

   initial begin
      a_rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ack[i] = 1'b0; pcw[i] = 1'b0; pop[i] = 1'b0; mdata[i] = '0;
      end
      pcalu_a = '0;
      pcalu_b = '0;
      repeat (3) tick();

      // reset state
      sel = 0;
      chk("rst_req", 48'(req[0]), 48'h0);
      chk("rst_addr", 48'(addr_a), 48'h0);
      chk("rst_valid", 48'(valid[0]), 48'h0);
      chk("rst_ir", 48'(ir[0]), 48'h0);
      chk("rst_k16", 48'(k16[0]), 48'h0);
      chk("rst_pc", 48'(pco_a), 48'h0);

      // sequential fetch until full
      a_rst = 1'b1;
      tick();
      chk("first_req", 48'(req[0]), 48'h1);
      chk("first_addr", 48'(addr_a), 48'h0);
      chk("pre_ack_valid", 48'(valid[0]), 48'h0);
      ack_word(16'h0000, 32'h1111_0000, 1'b1);
      chk("valid_after_ack", 48'(valid[0]), 48'h1);
      ack_word(16'h0004, 32'h2222_0001, 1'b1);
      ack_word(16'h0008, 32'h3333_0002, 1'b1);
      ack_word(16'h000C, 32'h4444_0003, 1'b1);
      repeat (4) begin
         tick();
         chk("full_stall", 48'(req[0]), 48'h0);
      end

      // pop order; refill request follows the first pop
      for (int i = 0; i < 4; i++) begin
         pop_chk();
         if (i == 0) chk("no_req_yet", 48'(req[0]), 48'h0);
         if (i == 1) begin
            chk("req_after_pop", 48'(req[0]), 48'h1);
            chk("req_after_pop_addr", 48'(addr_a), 48'h0010);
         end
      end
      chk("drained", 48'(valid[0]), 48'h0);
      ack_word(16'h0010, 32'h5555_0004, 1'b1);

      // redirect while idle
      redirect(16'h0103);
      chk("redir_idle_valid", 48'(valid[0]), 48'h0);
      ack_word(16'h0100, 32'hA0A0_0100, 1'b1);

      // redirect during wait, ack delayed
      wait_req();
      chk("wait_addr", 48'(addr_a), 48'h0104);
      redirect(16'h0200);
      chk("redir_wait_valid", 48'(valid[0]), 48'h0);
      repeat (2) begin
         chk("held_req", 48'(req[0]), 48'h1);
         chk("held_addr", 48'(addr_a), 48'h0104);
         tick();
      end
      ack_word(16'h0104, 32'hDEAD_BEEF, 1'b0);
      chk("stale_dropped", 48'(valid[0]), 48'h0);
      ack_word(16'h0200, 32'hB0B0_0200, 1'b1);
      chk("post_redir_valid", 48'(valid[0]), 48'h1);

      // pop and ack together at count 2
      ack_word(16'h0204, 32'hC0C0_0204, 1'b1);
      wait_req();
      chk("simul_addr", 48'(addr_a), 48'h0208);
      head_chk();
      pop[0]   = 1'b1;
      ack[0]   = 1'b1;
      mdata[0] = 32'hD0D0_0208;
      sb.push_back({32'hD0D0_0208, 16'h0208});
      tick();
      pop[0] = 1'b0;
      ack[0] = 1'b0;
      pop_chk();
      pop_chk();
      chk("count_stayed_2", 48'(valid[0]), 48'h0);

      // redirect and ack together
      wait_req();
      chk("redir_ack_addr", 48'(addr_a), 48'h020C);
      ack[0]   = 1'b1;
      mdata[0] = 32'hEEEE_020C;
      redirect(16'h0300);
      ack[0] = 1'b0;
      chk("redir_ack_valid", 48'(valid[0]), 48'h0);
      ack_word(16'h0300, 32'hF0F0_0300, 1'b1);
      pop_chk();

      // back-to-back redirects
      wait_req();
      redirect(16'h0400);
      redirect(16'h0500);
      ack_word(16'h0304, 32'h1234_5678, 1'b0);
      ack_word(16'h0500, 32'h9ABC_0500, 1'b1);
      pop_chk();

      // reset mid-transaction with a late ack
      wait_req();
      a_rst  = 1'b0;
      ack[0] = 1'b1;
      #1;
      chk("midrst_req", 48'(req[0]), 48'h0);
      chk("midrst_valid", 48'(valid[0]), 48'h0);
      tick();
      a_rst = 1'b1;
      tick();
      chk("late_ack_req", 48'(req[0]), 48'h1);
      chk("late_ack_addr", 48'(addr_a), 48'h0);
      chk("late_ack_valid", 48'(valid[0]), 48'h0);
      ack[0] = 1'b0;
      sb.delete();

      // small instance: address wrap 0xF -> 0x0 and pointer wrap at DEPTH=2
      sel = 1;
      wait_req();
      redirect(16'h0033);
      ack_word(16'h0000, 32'h0BAD_0000, 1'b0);
      ack_word(16'h0030, 32'hA000_5000, 1'b1);
      ack_word(16'h0034, 32'hA001_5001, 1'b1);
      repeat (3) begin
         tick();
         chk("b_full_stall", 48'(req[1]), 48'h0);
      end
      for (int k = 2; k < 10; k++) begin
         logic [5:0] ba;
         ba = 6'(((12 + k) % 16) * 4);
         pop_chk();
         ack_word({10'b0, ba}, {16'(16'hA000 + k), 16'(16'h5000 + k)}, 1'b1);
      end
      pop_chk();
      pop_chk();
      chk("b_drained", 48'(valid[1]), 48'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised prefetching instruction fetch unit for the 65HE06 core. It sits between the 32-bit instruction memory port and the decoder, and replaces the single-entry fetch register with a DEPTH-entry queue. Each 32-bit fetch word holds the opcode half (ir) and the constant half (k16). The unit keeps fetching ahead while the decoder stalls, and flushes on an ALU-driven PC redirect.

## Interface
- ADDR_W, 14: word-address width; byte PC width is ADDR_W+2.
- DEPTH, 4: queue entries; power of two, minimum 2.
- clk  in  1  clock, rising edge.
- a_rst  in  1  reset, asynchronous, active-low.
- mem_req  out  1  fetch request; held until mem_ack.
- mem_addr  out  ADDR_W+2  byte address of the request; low 2 bits always 0.
- mem_ack  in  1  request accepted; mem_data valid in the same cycle.
- mem_data  in  32  fetched word: [31:16] is ir, [15:0] is k16.
- pc_w  in  1  redirect strobe from the ALU.
- pc_alu  in  ADDR_W+2  redirect target; bits [1:0] are ignored.
- ir_pop  in  1  decoder consumes the head entry.
- ir_valid  out  1  head entry present.
- ir_out  out  16  head opcode.
- k16_out  out  16  head constant.
- pc_out  out  ADDR_W+2  byte address of the head entry.

## Operation
- **State**
  - fpc (ADDR_W): next fetch word address.
  - Queue storage, read pointer rp and write pointer wp: log2(DEPTH) bits each, wrap modulo DEPTH.
  - count: 0..DEPTH.
  - busy: request outstanding.
  - drop: outstanding request is stale.
- **Credit rule:** a new request is issued only when count + busy < DEPTH. The queue can never overflow.
- **Memory FSM, states IDLE and WAIT**
  - IDLE: if the credit rule holds and there is no redirect this cycle, assert mem_req with mem_addr = {fpc, 2'b00} and go to WAIT.
  - WAIT: hold mem_req and mem_addr stable until mem_ack.
  - On ack with drop = 0: push {mem_data, fpc}, increment fpc (wraps modulo 2^ADDR_W), return to IDLE.
  - On ack with drop = 1: discard the data, clear drop, return to IDLE.
  - mem_req and mem_addr are registered.
- **Queue**
  - Push writes at wp. Pop (ir_pop & ir_valid) advances rp.
  - Push and pop in the same cycle: count is unchanged.
  - ir_pop while empty is ignored.
- **Redirect (pc_w = 1)**
  - count, rp and wp are cleared.
  - fpc <= pc_alu[ADDR_W+1:2].
  - If in WAIT without ack: set drop.
  - An ack in the same cycle as a redirect is discarded.
  - Redirect has priority over pop and push in the same cycle.
  - Back-to-back redirects: the last one wins.
- **Outputs**
  - ir_valid = (count != 0).
  - ir_out, k16_out and pc_out are read combinationally from entry rp.
  - pc_out = {entry_pc, 2'b00}.
- **Reset:** fpc, pointers, count, busy, drop, mem_req, mem_addr and all storage are 0. ir_valid, ir_out, k16_out and pc_out are 0.

## Timing
- First request: mem_req = 1 with mem_addr = 0 on the first clock edge after a_rst deasserts.
- Fetch-to-decode latency: an ack in cycle t makes the entry visible with ir_valid = 1 in cycle t+1.
- Sustained rate: one request per two cycles with zero-wait memory, since IDLE and WAIT alternate.
- Redirect in cycle t, no request outstanding: ir_valid = 0 at t+1; the new mem_req is issued at t+1.
- Redirect in cycle t, request outstanding: ir_valid = 0 at t+1; the new mem_req is issued in the cycle after the stale ack.
- Full queue with decoder stalled: mem_req stays 0 until a pop; a request issues in the cycle after the pop.
- Reset mid-transaction: all state clears immediately; a late mem_ack after reset is ignored because busy = 0.

## Test plan
- **Reset and sequential fetch:** release reset, ack every request, no pops → requests go out to addresses 0x0, 0x4, 0x8, 0xC; ir_valid rises one cycle after the first ack; no further request once count = 4.
- **Pop order:** with the queue holding words 0x11110000..0x44440003, pop every cycle → ir_out reads 0x1111, 0x2222, 0x3333, 0x4444; pc_out reads 0, 4, 8, 12; a new request issues after the first pop.
- **Redirect while idle:** with pc_alu = 0x0103 and pc_w pulsed → ir_valid = 0 next cycle; next mem_addr = 0x0100.
- **Redirect during wait:** redirect to 0x0200 while mem_ack is delayed 3 cycles → the stale data is never pushed; the next request is to 0x0200.
- **Simultaneous events:** pop and ack in the same cycle at count = 2 → count stays 2. Redirect and ack in the same cycle → queue empty and data dropped.
- **Wrap-around:** with ADDR_W = 4, fetch from word address 0xF → next request is to word address 0x0 (byte address 0x00). With DEPTH = 2, the pointers wrap and the order is preserved over 10 pushes and pops.
